// File: rtl/mmap_m_axi_pkg.sv
// Shared types and default sizing for the AXI write-data drain block.
package mmap_m_axi_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DEPTH      = 63;
  localparam int DEF_LEN_WIDTH  = 8;

  // Burst sequencer states: waiting for a command, or streaming its beats.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Byte-enable width that goes with a data beat.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mmap_m_axi_wdata_srl.sv
// Shift-register beat store: a push enters slot 0 and moves every older
// beat up one slot; the reader picks any slot by address (oldest lives at
// occupancy-1, tracked by the parent).
module mmap_m_axi_wdata_srl #(
  parameter int WIDTH      = 36,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  shift_en,
  input  logic [WIDTH-1:0]      shift_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Shift a new beat in at slot 0, ageing every stored beat by one slot.
  // NOTE: the array has no reset; validity is carried entirely by the
  // parent's occupancy counter, so clearing storage would only cost logic.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= shift_in;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Addressed read; addresses past the last slot return zero.
  always_comb begin
    rd_data = '0;
    if (rd_addr < DEPTH_A) begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/mmap_m_axi_wdata_drain.sv
// AXI master W-channel drain: buffers user data beats and streams them out
// as bursts whose lengths arrive on a separate command port.
// Optional feature: define MMAP_M_AXI_WDATA_OUTREG_EN to add one register
// stage on wvalid/wdata/wstrb/wlast (one cycle of extra first-beat latency,
// full throughput kept). Without it the W channel is driven combinationally
// from the oldest buffered beat.
module mmap_m_axi_wdata_drain
  import mmap_m_axi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] din_strb,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    busy
);

  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
  localparam int BEAT_WIDTH = DATA_WIDTH + STRB_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   count;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    beat_cnt;
  logic                    push;
  logic                    pop;
  logic                    cmd_fire;

  // Storage-side view of the oldest beat, before any output register.
  logic                    s_valid;
  logic                    s_ready;
  logic                    s_last;
  logic [BEAT_WIDTH-1:0]   s_beat;
  logic [DATA_WIDTH-1:0]   s_data;
  logic [STRB_WIDTH-1:0]   s_strb;

  assign din_ready = (count != DEPTH_A);
  assign push      = din_valid & din_ready;
  assign pop       = s_valid & s_ready;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign s_last    = (beat_cnt == len_q);

  // Oldest beat sits one below the occupancy count.
  assign rd_addr = count - ADDR_WIDTH'(1);

  mmap_m_axi_wdata_srl #(
    .WIDTH      (BEAT_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk      (clk),
    .shift_en (push),
    .shift_in ({din_strb, din}),
    .rd_addr  (rd_addr),
    .rd_data  (s_beat)
  );

  // Stale slots never reach the bus: data and strobes read as zero unless
  // a beat is actually being offered.
  assign {s_strb, s_data} = s_valid ? s_beat : '0;

  // State register.
  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values; = here would make results depend on block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept a command when idle, leave once its last beat pops.
  // NOTE: state_nxt takes a default before the case so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = BURST;
      BURST:   if (pop && s_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: command handshake, busy flag, storage valid.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    s_valid   = 1'b0;
    case (state)
      IDLE:  cmd_ready = 1'b1;
      BURST: begin
        busy    = 1'b1;
        s_valid = (count != '0);
      end
      default: ;
    endcase
  end

  // Burst length capture and beat counting; an empty buffer simply stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      beat_cnt <= '0;
    end else if (cmd_fire) begin
      len_q    <= cmd_len;
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + LEN_WIDTH'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count, and therefore
  // the oldest-beat address, unchanged since the shift moves that beat up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + ADDR_WIDTH'(1);
        2'b01:   count <= count - ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef MMAP_M_AXI_WDATA_OUTREG_EN
  logic                  out_valid;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic [STRB_WIDTH-1:0] out_strb;

  // The stage takes a new beat whenever it is empty or draining this cycle,
  // so back-to-back beats still flow one per clock.
  assign s_ready = ~out_valid | wready;

  // Output register stage; holds its beat unchanged while wready is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_strb  <= '0;
    end else if (s_ready) begin
      out_valid <= s_valid;
      out_last  <= s_valid & s_last;
      out_data  <= s_data;
      out_strb  <= s_strb;
    end
  end

  assign wvalid = out_valid;
  assign wlast  = out_last;
  assign wdata  = out_data;
  assign wstrb  = out_strb;
`else
  // Direct drive: the oldest beat is presented as soon as the burst is live,
  // and stays put until wready because nothing pops without it.
  assign s_ready = wready;
  assign wvalid  = s_valid;
  assign wlast   = s_valid & s_last;
  assign wdata   = s_data;
  assign wstrb   = s_strb;
`endif

endmodule

// File: tb/tb_mmap_m_axi_wdata_drain.sv
// Bench for mmap_m_axi_wdata_drain: table-driven bursts plus hand-written
// full-buffer and mid-burst-reset sequences, with a scoreboard of expected
// beats checked by a W-channel monitor.
`timescale 1ns/1ps
module tb_mmap_m_axi_wdata_drain;
  import mmap_m_axi_pkg::*;

  localparam int DW    = DEF_DATA_WIDTH;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DEPTH = DEF_DEPTH;
  localparam int LW    = DEF_LEN_WIDTH;
  localparam int SW    = DW / 8;
`ifdef MMAP_M_AXI_WDATA_OUTREG_EN
  localparam int OREG_LAT = 1;
`else
  localparam int OREG_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] din;
  logic [SW-1:0] din_strb;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast;
  logic          busy;

  mmap_m_axi_wdata_drain #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .din_strb  (din_strb),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } beat_t;

  typedef struct {
    int unsigned   len;
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    logic [SW-1:0] strb;
    bit            pre;       // push all beats before the command
    int            gap;       // idle cycles after each push
    bit            wmode;     // 0: wready held high, 1: wready toggles
    logic [DW-1:0] exp_last;  // data expected on the wlast beat
    int            exp_lat;   // first-beat latency in cycles, -1 = unchecked
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  beat_t       sb[$];
  int unsigned cmd_q[$];
  int          bidx = 0;
  int          hs_count = 0;
  logic [DW-1:0] last_data;
  bit          busy_chk = 0;
  bit          stall_prev = 0;
  bit          wtoggle = 0;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_strb;
  logic          prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // W-channel monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
      busy_chk   = 0;
    end else begin
      if (busy_chk) begin
        check("busy_after_last", busy, 0);
        busy_chk = 0;
      end
      if (stall_prev) begin
        check("hold_wvalid", wvalid, 1);
        check("hold_wdata", wdata, prev_data);
        check("hold_wstrb", wstrb, prev_strb);
        check("hold_wlast", wlast, prev_last);
      end
      if (wvalid) check("wvalid_only_when_buffered", sb.size() != 0, 1);
      if (wvalid && wready) begin
        check("beat_expected", (sb.size() != 0) && (cmd_q.size() != 0), 1);
        if (sb.size() != 0 && cmd_q.size() != 0) begin
          beat_t e;
          bit    exp_last;
          e = sb.pop_front();
          exp_last = (bidx == int'(cmd_q[0]));
          check("wdata", wdata, e.data);
          check("wstrb", wstrb, e.strb);
          check("wlast", wlast, exp_last);
          hs_count++;
          if (exp_last) begin
            last_data = wdata;
            busy_chk  = 1;
            void'(cmd_q.pop_front());
            bidx = 0;
          end else begin
            bidx++;
          end
        end
      end
      stall_prev = wvalid && !wready;
      prev_data  = wdata;
      prev_strb  = wstrb;
      prev_last  = wlast;
    end
  end

  // Optional wready toggler, active only while wtoggle is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wtoggle) wready = ~wready;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit acc = 0;
    din_valid = 1'b1;
    din       = d;
    din_strb  = s;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk);
      acc = din_ready;
      tick();
    end
    din_valid = 1'b0;
    if (acc) sb.push_back('{data: d, strb: s});
    else check("push_accepted", acc, 1);
  endtask

  // One cycle offering a beat with a chosen wready; reports acceptance.
  task automatic offer_cycle(input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input logic w, output bit acc);
    wready    = w;
    din_valid = 1'b1;
    din       = d;
    din_strb  = s;
    @(negedge clk);
    acc = din_ready;
    tick();
    din_valid = 1'b0;
    if (acc) sb.push_back('{data: d, strb: s});
  endtask

  task automatic issue_cmd(input int unsigned len, input bit measure, output int lat);
    bit acc = 0;
    lat       = -1;
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      check("cmd_accepted", acc, 1);
      return;
    end
    cmd_q.push_back(len);
    if (measure) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (wvalid) begin
          lat = k;
          break;
        end
      end
      tick();
    end
  endtask

  task automatic wait_drain(output bit done);
    done = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      tick();
      if (sb.size() == 0 && cmd_q.size() == 0 && !wvalid) done = 1;
    end
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    int lat;
    bit done;
    last_data = 'x;
    wtoggle   = v.wmode;
    if (!v.wmode) wready = 1'b1;
    if (v.pre) begin
      for (int i = 0; i <= int'(v.len); i++) push_beat(v.base + v.step * DW'(i), v.strb);
      issue_cmd(v.len, v.exp_lat >= 0, lat);
      if (v.exp_lat >= 0) check({tag, "_first_beat_latency"}, lat, v.exp_lat);
    end else begin
      issue_cmd(v.len, 1'b0, lat);
      for (int i = 0; i <= int'(v.len); i++) begin
        push_beat(v.base + v.step * DW'(i), v.strb);
        repeat (v.gap) tick();
      end
    end
    wait_drain(done);
    check({tag, "_drained"}, done, 1);
    check({tag, "_last_data"}, last_data, v.exp_last);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_cmd_ready_idle"}, cmd_ready, 1);
    wtoggle = 0;
    wready  = 1'b0;
  endtask

  vec_t vecs [5];

  initial begin
    int  lat;
    int  fill_n;
    int  base;
    bit  acc;
    bit  done;

    vecs[0] = '{len: 3, base: 32'h11, step: 32'h11, strb: 4'hF, pre: 1, gap: 0,
                wmode: 0, exp_last: 32'h44, exp_lat: OREG_LAT};
    vecs[1] = '{len: 0, base: 32'hAA, step: 32'h0, strb: 4'hF, pre: 1, gap: 0,
                wmode: 0, exp_last: 32'hAA, exp_lat: OREG_LAT};
    vecs[2] = '{len: 7, base: 32'h0BEE_0000, step: 32'h1, strb: 4'h3, pre: 0, gap: 2,
                wmode: 1, exp_last: 32'h0BEE_0007, exp_lat: -1};
    vecs[3] = '{len: 5, base: 32'hCAFE_0100, step: 32'h100, strb: 4'h9, pre: 0, gap: 0,
                wmode: 1, exp_last: 32'hCAFE_0600, exp_lat: -1};
    vecs[4] = '{len: 2, base: 32'h8000_0001, step: 32'h10, strb: 4'h1, pre: 1, gap: 0,
                wmode: 1, exp_last: 32'h8000_0021, exp_lat: -1};

    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    din_strb  = '0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    wready    = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_busy", busy, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_din_ready", din_ready, 1);
    reset = 1'b0;
    tick();
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_din_ready", din_ready, 1);
    check("rel_wvalid", wvalid, 0);

    // Table-driven bursts.
    for (int i = 0; i < 5; i++) begin
      run_vector(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Full buffer, then pop-only, push+pop, push-only cycles.
    wready = 1'b0;
    fill_n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      push_beat(32'hF000_0000 + DW'(fill_n), SW'(fill_n));
      fill_n++;
    end
    check("full_din_ready", din_ready, 0);
    last_data = 'x;
    issue_cmd(255, 1'b0, lat);
    tick();
    tick();
    for (int k = 0; k < 4 && din_ready; k++) begin
      push_beat(32'hF000_0000 + DW'(fill_n), SW'(fill_n));
      fill_n++;
    end
    check("refull_din_ready", din_ready, 0);
    offer_cycle(32'hF000_0000 + DW'(fill_n), SW'(fill_n), 1'b1, acc);
    check("pop_only_push_refused", acc, 0);
    check("pop_only_din_ready", din_ready, 1);
    offer_cycle(32'hF000_0000 + DW'(fill_n), SW'(fill_n), 1'b1, acc);
    if (acc) fill_n++;
    check("push_pop_accepted", acc, 1);
    check("push_pop_din_ready", din_ready, 1);
    offer_cycle(32'hF000_0000 + DW'(fill_n), SW'(fill_n), 1'b0, acc);
    if (acc) fill_n++;
    check("push_only_accepted", acc, 1);
    check("push_only_full", din_ready, 0);
    wready = 1'b1;
    while (fill_n < 256) begin
      push_beat(32'hF000_0000 + DW'(fill_n), SW'(fill_n));
      fill_n++;
    end
    wait_drain(done);
    check("fill_drained", done, 1);
    check("fill_last_data", last_data, 32'hF000_00FF);
    check("fill_busy_idle", busy, 0);
    wready = 1'b0;
    tick();

    // Reset in the middle of a five-beat burst after two beats went out.
    wready = 1'b1;
    for (int i = 0; i < 5; i++) push_beat(32'h5000_0000 + DW'(i), 4'hF);
    issue_cmd(4, 1'b0, lat);
    base = hs_count;
    for (int k = 0; k < 100 && hs_count < base + 2; k++) tick();
    check("beats_before_reset", hs_count - base, 2);
    reset = 1'b1;
    #1;
    check("midrst_wvalid", wvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_din_ready", din_ready, 1);
    check("midrst_wlast", wlast, 0);
    sb.delete();
    cmd_q.delete();
    bidx = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("postrst_cmd_ready", cmd_ready, 1);
    check("postrst_wvalid", wvalid, 0);
    run_vector(vecs[0], "after_reset");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
